// File: rtl/updown_mod_counter.sv
// updown_mod_counter
//
// General-purpose N-bit up/down counter with a runtime-programmable terminal
// value (max_val). The count range is 0..max_val inclusive. At the terminal
// value the counter either wraps (SATURATE=0) or holds (SATURATE=1).
//
// Parameters
//   N         counter width in bits, legal range 2..32
//   SATURATE  0: wrap at the terminal value, 1: hold at the terminal value
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-low reset (count, ovf cleared, tc forced low)
//   clr       synchronous clear of count and ovf, highest priority
//   load      synchronous load of min(load_val, max_val), ovf unchanged
//   load_val  value to load
//   en        count enable
//   up        direction, 1 = up, 0 = down
//   max_val   terminal value
//   count     current count, registered
//   tc        terminal-count strobe, high in the cycle whose edge performs a
//             terminal step (combinational from state and inputs)
//   ovf       sticky flag, set on every enabled terminal step
module updown_mod_counter #(
  parameter int unsigned N        = 4,
  parameter bit          SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         en,
  input  logic         up,
  input  logic [N-1:0] max_val,
  output logic [N-1:0] count,
  output logic         tc,
  output logic         ovf
);

  logic [N-1:0] load_clamped;
  logic [N-1:0] step_count;
  logic         term_up;
  logic         term_dn;
  logic         above_max;
  logic         term;
  logic         step;
  logic         term_step;

  // A count above max_val (after max_val shrinks) is terminal when counting up.
  assign term_up   = (count >= max_val);
  assign term_dn   = (count == '0);
  assign above_max = (count > max_val);
  assign term      = up ? term_up : term_dn;

  assign load_clamped = (load_val > max_val) ? max_val : load_val;

  assign step      = en & ~clr & ~load;
  assign term_step = step & term;

  assign tc = term_step & rst;

  // Next count for an enabled step. Every path stays within 0..max_val, so
  // raw N-bit overflow/underflow of the +1/-1 never reaches count.
  always_comb begin
    step_count = count;
    if (up) begin
      if (term_up) begin
        step_count = SATURATE ? max_val : '0;
      end else begin
        step_count = count + N'(1);
      end
    end else begin
      if (above_max) begin
        // Snap back into range; this is not a terminal step.
        step_count = max_val;
      end else if (term_dn) begin
        step_count = SATURATE ? '0 : max_val;
      end else begin
        step_count = count - N'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
    end else if (en) begin
      count <= step_count;
      if (term) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule
